// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - exhaustive input sweep sequencer and checker for a gate under test
//
// Drives every input code of an N_IN-input gate in ascending order, holds each
// code for SETTLE cycles, then samples gate_out against the TRUTH table.
// Mismatches (including X/Z on gate_out) are accumulated in err_cnt/fail_map.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   sweep request, honoured only when idle
//   abort     in   cancels a running sweep (no done pulse)
//   gate_out  in   output of the gate under test
//   drv       out  gate input vector (N_IN bits)
//   busy      out  sweep in progress
//   done      out  one-cycle completion pulse
//   pass      out  last sweep completed with zero mismatches (held)
//   err_cnt   out  mismatch count (N_IN+1 bits, cannot wrap)
//   fail_map  out  bit k set when code k mismatched

module gate_sweep_ctrl #(
  parameter int                      N_IN   = 2,
  parameter int                      SETTLE = 3,
  parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b0111
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    gate_out,
  output logic [N_IN-1:0]         drv,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN:0]           err_cnt,
  output logic [(1<<N_IN)-1:0]    fail_map
);

  localparam int         NV        = 1 << N_IN;
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [N_IN-1:0]   drv_n;
  logic              busy_n, done_n, pass_n;
  logic [N_IN:0]     err_n;
  logic [NV-1:0]     fmap_n;
  logic              exp_bit;
  logic              mism;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      drv      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_map <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      drv      <= drv_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      err_cnt  <= err_n;
      fail_map <= fmap_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    drv_n   = drv;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    err_n   = err_cnt;
    fmap_n  = fail_map;

    // Written as if/else so an X or Z on gate_out falls into the mismatch
    // branch instead of propagating an unknown into the counters.
    exp_bit = TRUTH[drv];
    mism    = 1'b1;
    if (gate_out == exp_bit) begin
      mism = 1'b0;
    end

    case (state)
      S_IDLE: begin
        // abort outranks start, so a simultaneous request is dropped
        if (start && !abort) begin
          state_n = S_SETTLE;
          drv_n   = '0;
          cnt_n   = SETTLE_M1;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          err_n   = '0;
          fmap_n  = '0;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_n = S_IDLE;
          drv_n   = '0;
          busy_n  = 1'b0;
          pass_n  = 1'b0;
        end else if (cnt == 8'd0) begin
          state_n = S_SAMPLE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end

      S_SAMPLE: begin
        // an abort here discards this vector's compare entirely
        if (abort) begin
          state_n = S_IDLE;
          drv_n   = '0;
          busy_n  = 1'b0;
          pass_n  = 1'b0;
        end else begin
          if (mism) begin
            fmap_n[drv] = 1'b1;
            err_n       = err_cnt + (N_IN+1)'(1);
          end
          if (&drv) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = !mism && (err_cnt == '0);
          end else begin
            state_n = S_SETTLE;
            drv_n   = drv + N_IN'(1);
            cnt_n   = SETTLE_M1;
          end
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Exhaustive-sweep sequencer for a small switch-level gate under test (default: the 2-input CMOS NAND). On a start request it drives every input combination in ascending binary order and waits a programmable settle time per vector. It then samples the gate output and compares it against a parameterised truth table, accumulating a mismatch count and per-vector fail map. It replaces hand-written stimulus loops in gate benches and also serves as an on-chip self-check wrapper around gate cells.

## Interface
- N_IN, 2, number of gate inputs; sweep length is 2**N_IN vectors
- SETTLE, 3, cycles a vector is held before sampling; legal range 1..255
- TRUTH, 4'b0111, expected output table, width 2**N_IN; bit k = expected output for input code k (default = NAND)

- clk  in  1  sole clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  sweep request, sampled only in IDLE
- abort  in  1  synchronous cancel of a running sweep
- gate_out  in  1  output of gate under test, same clock domain
- drv  out  N_IN  gate input vector; MSB = in1, LSB = in2 for the NAND
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  single-cycle completion pulse
- pass  out  1  1 = last sweep had zero mismatches; valid from done, held
- err_cnt  out  N_IN+1  mismatch count of last/current sweep
- fail_map  out  2**N_IN  bit k set if vector k mismatched

## Operation
- Reset values: drv=0, busy=0, done=0, pass=0, err_cnt=0, fail_map=0, state IDLE, internal code=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 → SETTLE. Same edge: drv←0, settle counter←SETTLE-1, busy←1, pass/err_cnt/fail_map cleared.
- SETTLE: counter decrements each cycle. At counter==0 → SAMPLE. drv held constant.
- SAMPLE: compare gate_out with TRUTH[drv]. Mismatch, including gate_out X or Z, sets fail_map[drv] and increments err_cnt.
  - If drv==2**N_IN-1 → DONE.
  - Otherwise drv←drv+1, counter←SETTLE-1, → SETTLE.
- DONE: done=1 for exactly one cycle. busy=0. pass=(err_cnt==0). → IDLE. drv keeps the last code.
- All outputs are registered; no combinational path from inputs to outputs.
- start while busy: ignored, no queueing.
- abort while busy (SETTLE or SAMPLE): next edge → IDLE, drv←0, busy←0, no done pulse, pass←0. err_cnt/fail_map keep their partial values. abort has priority over a same-cycle SAMPLE compare; that compare is discarded.
- abort in IDLE or DONE: no effect. start and abort both high in IDLE: abort wins, sweep not started.
- rst_n low at any time, including mid-sweep: all outputs go to reset values immediately; the sweep is not resumed.
- err_cnt cannot wrap: the maximum value 2**N_IN fits in N_IN+1 bits.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE, 1 in SAMPLE.
- gate_out is sampled at the rising edge that ends SAMPLE, SETTLE+1 edges after drv changed.
- done is high in the cycle following edge 2**N_IN*(SETTLE+1), counted from the start-acceptance edge. Default: 16 edges.
- Back-to-back sweeps: start may be accepted in the IDLE cycle immediately after done. Minimum restart gap is 1 cycle.

## Test plan
- Correct NAND model, defaults, start pulse → drv = 00,01,10,11, each held 4 cycles. done pulse 16 edges after acceptance. pass=1, err_cnt=0, fail_map=0000.
- Gate output stuck at 1 → fail_map=1000, err_cnt=1, pass=0. Stuck at 0 → fail_map=0111, err_cnt=3, pass=0.
- gate_out driven Z during code 00 only → fail_map=0001, err_cnt=1. Confirms X/Z counts as a mismatch.
- start re-asserted during vector 01 → ignored; done still at edge 16. A second start the cycle after done → new sweep with results cleared.
- abort during SAMPLE of vector 10 → next cycle IDLE, busy=0, drv=00, no done. fail_map shows only vectors 00,01 results. start+abort together in IDLE → stays IDLE.
- rst_n pulsed low mid-sweep (vector 01) → all outputs 0 asynchronously. After release, a fresh start yields a normal 16-edge sweep. Repeat with SETTLE=1: done at edge 8.
